// File: rtl/mul_sched_pkg.sv
// Shared types and widths for the mul_sched multiplier scheduler.
package mul_sched_pkg;

  localparam int OPW      = 16;
  localparam int PRW      = 32;
  localparam int MAX_NREQ = 8;
  localparam int IDW      = $clog2(MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    DONE     = 2'd2
  } req_state_e;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
  } tag_t;

endpackage

// File: rtl/mul_sched_arb.sv
// One-hot arbiter for mul_sched: round-robin by default, fixed lowest-index
// priority when MUL_SCHED_FIXED_PRIO_EN is defined.
module mul_sched_arb
  import mul_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] eligible,
  output logic [NREQ-1:0] grant
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef MUL_SCHED_FIXED_PRIO_EN
  logic unused_clk_reset;
  assign unused_clk_reset = clk ^ reset;

  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && eligible[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
      end
    end
  end
`else
  logic [PW-1:0] last_grant_q, last_grant_d;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    logic found;
    int   idx;
    grant        = '0;
    last_grant_d = last_grant_q;
    found        = 1'b0;
    idx          = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        last_grant_d = PW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= PW'(NREQ - 1);
    else       last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: rtl/mul_sched.sv
// Shares one external pipelined multiplier among NREQ requesters.
// Arbitration mode is selected by MUL_SCHED_FIXED_PRIO_EN (see mul_sched_arb).
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*OPW-1:0] req_a,
  input  logic [NREQ*OPW-1:0] req_b,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [NREQ*PRW-1:0] rsp_data,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic [PRW-1:0]      mul_out,
  output logic                busy
);

  req_state_e     state_q    [NREQ];
  req_state_e     state_d    [NREQ];
  logic [PRW-1:0] rsp_data_q [NREQ];
  logic [PRW-1:0] rsp_data_d [NREQ];
  tag_t           tag_q      [MUL_LAT+1];
  tag_t           tag_d      [MUL_LAT+1];
  logic [OPW-1:0] mul_a_q, mul_a_d;
  logic [OPW-1:0] mul_b_q, mul_b_d;
  logic [NREQ-1:0] eligible, grant;
  tag_t           cap_tag;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++)
      eligible[i] = req_valid[i] && (state_q[i] == IDLE);
  end

  mul_sched_arb #(.NREQ(NREQ)) u_arb (
    .clk      (clk),
    .reset    (reset),
    .eligible (eligible),
    .grant    (grant)
  );

  assign req_ready = grant;

  // The tag travels alongside the operands so the product lands at its owner.
  always_comb begin
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    tag_d[0] = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        mul_a_d  = req_a[OPW*i +: OPW];
        mul_b_d  = req_b[OPW*i +: OPW];
        tag_d[0] = '{valid: 1'b1, id: IDW'(i)};
      end
    end
    for (int s = 1; s <= MUL_LAT; s++)
      tag_d[s] = tag_q[s-1];
  end

  assign cap_tag = tag_q[MUL_LAT];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      state_d[i]    = state_q[i];
      rsp_data_d[i] = rsp_data_q[i];
      case (state_q[i])
        IDLE:     if (grant[i]) state_d[i] = INFLIGHT;
        INFLIGHT: begin
          if (cap_tag.valid && (cap_tag.id == IDW'(i))) begin
            state_d[i]    = DONE;
            rsp_data_d[i] = mul_out;
          end
        end
        DONE:     if (rsp_ready[i]) state_d[i] = IDLE;
        default:  state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    busy      = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i]             = (state_q[i] == DONE);
      rsp_data[PRW*i +: PRW]   = rsp_data_q[i];
      if (state_q[i] != IDLE) busy = 1'b1;
    end
  end

  assign mul_a = mul_a_q;
  assign mul_b = mul_b_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_a_q <= '0;
      mul_b_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        state_q[i]    <= IDLE;
        rsp_data_q[i] <= '0;
      end
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      for (int i = 0; i < NREQ; i++) begin
        state_q[i]    <= state_d[i];
        rsp_data_q[i] <= rsp_data_d[i];
      end
      for (int s = 0; s <= MUL_LAT; s++) tag_q[s] <= tag_d[s];
    end
  end

endmodule

// File: doc/mul_sched.md
# mul_sched

Time-multiplexes one external 16x16 radix-4 Booth multiplier (`booth2multiplier`) among `NREQ` requesters. Each requester may have one product in flight. A round-robin arbiter issues at most one operand pair per cycle into the multiplier pipeline. The returned product is steered back to the originating requester through a valid/ready response port. The block sits between the requester clients and the shared multiplier instance, and owns that multiplier's A/B inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `MUL_LAT`, 1: cycles from `mul_a`/`mul_b` valid until the matching `mul_out` is valid; 1..4.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NREQ: per-requester request strobe.
- `req_ready` out NREQ: per-requester accept; a request transfers when valid & ready.
- `req_a` in NREQ*16: operand A, requester i at bits [16i+15:16i].
- `req_b` in NREQ*16: operand B, same packing.
- `rsp_valid` out NREQ: product available for requester i.
- `rsp_ready` in NREQ: requester i takes its product.
- `rsp_data` out NREQ*32: product for requester i at [32i+31:32i].
- `mul_a` out 16: registered operand A to the multiplier.
- `mul_b` out 16: registered operand B to the multiplier.
- `mul_out` in 32: product from the multiplier.
- `busy` out 1: high while any requester is not IDLE.

## Operation
- Each requester has a 2-bit state: IDLE, INFLIGHT, DONE.
- IDLE -> INFLIGHT when the request is accepted.
- INFLIGHT -> DONE when its product is captured.
- DONE -> IDLE when `rsp_valid[i] & rsp_ready[i]`.
- Eligibility: requester i is eligible when `req_valid[i]` and state[i] == IDLE.
- Arbitration: round-robin among eligible requesters. Search starts at (last_grant+1) mod NREQ. `last_grant` updates only on an accept.
- `req_ready` is combinational, one-hot or zero. It is high only for the selected eligible requester.
- On accept of i: `mul_a` <= A_i and `mul_b` <= B_i. A tag pipe of MUL_LAT+1 stages shifts {valid, id=i}.
- When the tag pipe outputs a valid tag: `rsp_data[id]` <= `mul_out` and state[id] -> DONE.
- `mul_out` is not interpreted: the product is passed through bit-exact. Signedness is whatever the multiplier implements.
- `mul_a`/`mul_b` hold their last value when no grant occurs.
- `rsp_data[i]` is stable while `rsp_valid[i]` is high.
- Each requester has at most one outstanding operation, so capture never collides with a pending DONE.
- Same-cycle `rsp_ready` handshake and new `req_valid` from one requester: the response completes this cycle, but the requester is not eligible until the following cycle, because eligibility uses the registered state.

## Timing
- Request accepted in cycle t.
- `mul_a`/`mul_b` are valid in cycle t+1.
- `mul_out` is valid in cycle t+1+MUL_LAT.
- `rsp_valid` rises in cycle t+2+MUL_LAT. With MUL_LAT=1 this is 3 cycles after accept.
- Throughput: one issue per cycle across requesters. Per requester, at best one issue per MUL_LAT+3 cycles.
- Reset values:
  - all states IDLE;
  - `req_ready`, `rsp_valid`, `busy` = 0;
  - `mul_a`, `mul_b`, `rsp_data` = 0;
  - tag pipe cleared;
  - `last_grant` = NREQ-1, so requester 0 wins first.
- Reset mid-operation: all in-flight tags are discarded. Late multiplier results are ignored, because the tag pipe has been cleared.

## Configuration
- `MUL_SCHED_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. `last_grant` is not used.
- Not defined: round-robin as described above.
- Both modes use identical ports and timing.

## Structure
- Shared package `mul_sched_pkg` holds:
  - state enum IDLE=2'd0, INFLIGHT=2'd1, DONE=2'd2;
  - widths `OPW=16` and `PRW=32`;
  - `MAX_NREQ=8`.
- Sub-module `mul_sched_arb`: NREQ-wide arbiter, eligible vector in, one-hot grant out, with the round-robin pointer inside. The macro selects the variant inside this sub-module.
- The multiplier is instantiated by the parent; this block only drives its operands and reads its product.

## Test plan
- Reset held 2 cycles -> all outputs 0. Release, then req0 = 345 x 123 -> `mul_a`=345 and `mul_b`=123 at t+1; `rsp_valid[0]` at t+3 with `rsp_data[0]`=42435.
- req0 = 789 x 987 and req1 = 32245 x 32235 requested in the same cycle, from reset -> req0 granted first, req1 the next cycle. Products 778743 and 1039417575 are delivered one cycle apart.
- All 4 requesters request continuously and hold `rsp_ready` = 1 -> grant order 0,1,2,3,0,… with no starvation. In the fixed-priority build, the order is 0,1,2,3 and then req0 is granted again on its first eligible cycle.
- req2 = 31978 x 23961 with `rsp_ready[2]` = 0 for 10 cycles -> `rsp_valid[2]` holds 766224858 stable; `req_ready[2]` stays 0; other requesters continue to be served.
- `reset` asserted one cycle after accepting req3 -> no `rsp_valid` ever appears for that request; after reset the state is IDLE and a new request completes normally.
- MUL_LAT = 3 build -> the accept-to-`rsp_valid` latency is 5 cycles; products are steered to the correct ids under back-to-back grants.
